// File: rtl/autorecord_if.sv
// Message/readback bundle between the autoplay capture block and its host.
`timescale 1ns/1ps
interface autorecord_if;
  logic        en;
  logic        clr;
  logic        clk_msg;
  logic [7:0]  msg;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic [15:0] len;
  logic        full;
  logic        recording;

  modport master (
    output en, clr, clk_msg, msg, rd_addr,
    input  rd_data, len, full, recording
  );

  modport slave (
    input  en, clr, clk_msg, msg, rd_addr,
    output rd_data, len, full, recording
  );
endinterface

// File: rtl/autorecord.sv
// Records clk_msg/msg key events as {delay,msg} words in beat/64 units into a RAM,
// with registered readback; runs on the 1 ms clk_play tick.
`timescale 1ns/1ps
module autorecord #(
  parameter int DEPTH          = 1394,
  parameter int MS_PER_BEATX64 = 9
) (
  input logic         clk_play,
  input logic         rst,
  autorecord_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (MS_PER_BEATX64 > 1) ? $clog2(MS_PER_BEATX64) : 1;
  localparam logic [15:0]   DEPTH16  = 16'(DEPTH);
  localparam logic [SW-1:0] SUB_LAST = SW'(MS_PER_BEATX64 - 1);

  typedef enum logic [1:0] {IDLE, REC, FULL} state_t;

  state_t        state, state_next;
  logic          msg_s1, msg_s2, msg_prev;
  logic          evt;
  logic [SW-1:0] sub, sub_next;
  logic [7:0]    beat, beat_next, beat_inc, delay;
  logic [15:0]   len, len_next;
  logic          tick, wr_en, full;
  logic [15:0]   rd_q;
  logic [15:0]   mem [DEPTH];

  assign evt      = msg_s2 & ~msg_prev;
  assign tick     = (sub == SUB_LAST);
  assign beat_inc = (beat == 8'hFF) ? 8'hFF : beat + 8'd1;
  // The event cycle itself counts toward the gap, so a tick landing on it is folded in.
  assign delay    = tick ? beat_inc : beat;
  assign full     = (len == DEPTH16);

  assign bus.len       = len;
  assign bus.full      = full;
  assign bus.recording = (state == REC);
  assign bus.rd_data   = rd_q;

  always_ff @(posedge clk_play or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      sub      <= '0;
      beat     <= '0;
      msg_s1   <= 1'b0;
      msg_s2   <= 1'b0;
      msg_prev <= 1'b0;
    end else begin
      state    <= state_next;
      len      <= len_next;
      sub      <= sub_next;
      beat     <= beat_next;
      msg_s1   <= bus.clk_msg;
      msg_s2   <= msg_s1;
      msg_prev <= msg_s2;
    end
  end

  always_comb begin
    state_next = state;
    len_next   = len;
    sub_next   = sub;
    beat_next  = beat;
    wr_en      = 1'b0;
    if (bus.clr) begin
      len_next   = '0;
      sub_next   = '0;
      beat_next  = '0;
      state_next = bus.en ? REC : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.en && !full) begin
            state_next = REC;
            sub_next   = '0;
            beat_next  = '0;
          end
        end
        REC: begin
          if (!bus.en) begin
            state_next = IDLE;
          end else if (evt) begin
            wr_en     = 1'b1;
            len_next  = len + 16'd1;
            sub_next  = '0;
            beat_next = '0;
            if (len + 16'd1 == DEPTH16) state_next = FULL;
          end else if (tick) begin
            sub_next  = '0;
            beat_next = beat_inc;
          end else begin
            sub_next = sub + 1'b1;
          end
        end
        FULL: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // RAM holds its contents across reset; only the index is cleared.
  always_ff @(posedge clk_play) begin
    if (wr_en) mem[len[AW-1:0]] <= {delay, bus.msg};
  end

  always_ff @(posedge clk_play or posedge rst) begin
    if (rst)                       rd_q <= '0;
    else if (bus.rd_addr < DEPTH16) rd_q <= mem[bus.rd_addr[AW-1:0]];
    else                           rd_q <= '0;
  end

endmodule
